cnnip_pool: RTL



---
 rtl/cnnip_pool.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/cnnip_pool.sv
// 2x2 stride-2 max-pooling engine: reads the feature map, writes the pooled map.
// Build option: define CNNIP_POOL_RELU_EN to clamp each pooled word at zero (fused ReLU).
module cnnip_pool #(
    parameter int unsigned FMAP_W   = 28,
    parameter int unsigned FMAP_H   = 28,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned SRC_BASE = 32'h3000,
    parameter int unsigned DST_BASE = 32'h4000
) (
    input  logic              clk_a,
    input  logic              arstz_aq,
    input  logic              CMD_START,
    output logic              CMD_BUSY,
    output logic              CMD_DONE,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_dout,
    output logic              wr_en,
    output logic [3:0]        wr_we,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_din
);

    localparam int unsigned OUT_W = FMAP_W / 2;
    localparam int unsigned OUT_H = FMAP_H / 2;
    localparam int unsigned PC_W  = (OUT_W > 1) ? $clog2(OUT_W) + 1 : 1;
    localparam int unsigned PR_W  = (OUT_H > 1) ? $clog2(OUT_H) + 1 : 1;

`ifdef CNNIP_POOL_RELU_EN
    localparam logic signed [DATA_W-1:0] MAX_INIT = '0;
`else
    localparam logic signed [DATA_W-1:0] MAX_INIT = {1'b1, {(DATA_W-1){1'b0}}};
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_RD0, S_RD1, S_RD2, S_RD3, S_WAIT, S_WR, S_DONE
    } state_t;

    state_t                    state;
    logic [PR_W-1:0]           pr;
    logic [PC_W-1:0]           pc;
    logic signed [DATA_W-1:0]  max_q;
    logic signed [DATA_W-1:0]  rd_s;
    logic signed [DATA_W-1:0]  cand;
    logic                      last_pc;
    logic                      last_pr;
    logic [PC_W-1:0]           pc_nxt;
    logic [PR_W-1:0]           pr_nxt;

    // Feature-map byte address of element (2r+dr, 2c+dc).
    function automatic logic [ADDR_W-1:0] src_addr(input logic [PR_W-1:0] r,
                                                   input logic [PC_W-1:0] c,
                                                   input logic dr, input logic dc);
        int unsigned row;
        int unsigned col;
        row = 2 * 32'(r) + 32'(dr);
        col = 2 * 32'(c) + 32'(dc);
        return ADDR_W'(SRC_BASE + 4 * (row * FMAP_W + col));
    endfunction

    function automatic logic [ADDR_W-1:0] dst_addr(input logic [PR_W-1:0] r,
                                                   input logic [PC_W-1:0] c);
        return ADDR_W'(DST_BASE + 4 * (32'(r) * OUT_W + 32'(c)));
    endfunction

    assign rd_s    = rd_dout;
    assign last_pc = (pc == PC_W'(OUT_W - 1));
    assign last_pr = (pr == PR_W'(OUT_H - 1));
    assign pc_nxt  = last_pc ? '0 : pc + PC_W'(1);
    assign pr_nxt  = last_pc ? pr + PR_W'(1) : pr;

    // Strict greater-than keeps the earlier word on ties.
    always_comb begin
        cand = max_q;
        if (rd_s > max_q) begin
            cand = rd_s;
        end
    end

    // Controller: outputs are registered for the state being entered.
    always_ff @(posedge clk_a or negedge arstz_aq) begin
        if (!arstz_aq) begin
            state    <= S_IDLE;
            pr       <= '0;
            pc       <= '0;
            max_q    <= '0;
            CMD_BUSY <= 1'b0;
            CMD_DONE <= 1'b0;
            rd_en    <= 1'b0;
            rd_addr  <= '0;
            wr_en    <= 1'b0;
            wr_we    <= '0;
            wr_addr  <= '0;
            wr_din   <= '0;
        end else begin
            CMD_DONE <= 1'b0;
            rd_en    <= 1'b0;
            rd_addr  <= '0;
            wr_en    <= 1'b0;
            wr_we    <= '0;
            wr_addr  <= '0;
            wr_din   <= '0;
            case (state)
                S_IDLE: begin
                    if (CMD_START) begin
                        state    <= S_RD0;
                        pr       <= '0;
                        pc       <= '0;
                        max_q    <= MAX_INIT;
                        CMD_BUSY <= 1'b1;
                        rd_en    <= 1'b1;
                        rd_addr  <= src_addr('0, '0, 1'b0, 1'b0);
                    end
                end
                S_RD0: begin
                    state   <= S_RD1;
                    rd_en   <= 1'b1;
                    rd_addr <= src_addr(pr, pc, 1'b0, 1'b1);
                end
                S_RD1: begin
                    state   <= S_RD2;
                    max_q   <= cand;
                    rd_en   <= 1'b1;
                    rd_addr <= src_addr(pr, pc, 1'b1, 1'b0);
                end
                S_RD2: begin
                    state   <= S_RD3;
                    max_q   <= cand;
                    rd_en   <= 1'b1;
                    rd_addr <= src_addr(pr, pc, 1'b1, 1'b1);
                end
                S_RD3: begin
                    state <= S_WAIT;
                    max_q <= cand;
                end
                S_WAIT: begin
                    state   <= S_WR;
                    max_q   <= cand;
                    wr_en   <= 1'b1;
                    wr_we   <= 4'b1111;
                    wr_addr <= dst_addr(pr, pc);
                    wr_din  <= cand;
                end
                S_WR: begin
                    pc <= pc_nxt;
                    pr <= pr_nxt;
                    if (last_pr && last_pc) begin
                        state    <= S_DONE;
                        CMD_DONE <= 1'b1;
                    end else begin
                        state   <= S_RD0;
                        max_q   <= MAX_INIT;
                        rd_en   <= 1'b1;
                        rd_addr <= src_addr(pr_nxt, pc_nxt, 1'b0, 1'b0);
                    end
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    CMD_BUSY <= 1'b0;
                end
                default: begin
                    state    <= S_IDLE;
                    CMD_BUSY <= 1'b0;
                end
            endcase
        end
    end

endmodule
